// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU instruction/data memory port arbiter.
package cpu_mem_pkg;

   localparam int unsigned TXN_ADDR_W = 32;
   localparam int unsigned TXN_DATA_W = 32;
   localparam logic [3:0]  WEB_NONE   = 4'hF;

   typedef enum logic [2:0] {
      IDLE,
      IM_BUSY,
      DM_BUSY,
      IM_DONE,
      DM_DONE
   } arb_state_t;

   typedef struct packed {
      logic [TXN_ADDR_W-1:0] addr;
      logic [TXN_DATA_W-1:0] wdata;
      logic [3:0]            we;
      logic                  is_dm;
   } txn_t;

endpackage

// File: rtl/arb_priority.sv
// Grant decision: DM wins unless IM has waited through STARVE_MAX DM grants.
module arb_priority
   import cpu_mem_pkg::*;
#(
   parameter int unsigned STARVE_MAX = 4,
   parameter int unsigned STARVE_W   = 3
) (
   input  logic                im_req,
   input  logic                dm_req,
   input  logic [STARVE_W-1:0] starve,
   output logic                grant_im,
   output logic                grant_dm
);

   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   assign grant_dm = dm_req && (!im_req || (starve < STARVE_LIM));
   assign grant_im = im_req && !grant_dm;

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Serialises CPU instruction and data accesses onto one multi-cycle memory port,
// with DM priority, an IM anti-starvation limit and an ack timeout.
module cpu_mem_arbiter
   import cpu_mem_pkg::*;
#(
   parameter int unsigned ADDR_W        = 32,
   parameter int unsigned DATA_W        = 32,
   parameter int unsigned TIMEOUT       = 255,
   parameter int unsigned IM_STARVE_MAX = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              IM_OE,
   input  logic [ADDR_W-1:0] IM_A,
   output logic [DATA_W-1:0] IM_DO,
   output logic              IM_Stall,
   output logic              IM_rDone,
   input  logic              DM_OE,
   input  logic [3:0]        DM_WEB,
   input  logic [ADDR_W-1:0] DM_A,
   input  logic [DATA_W-1:0] DM_DI,
   output logic [DATA_W-1:0] DM_DO,
   output logic              DM_Stall,
   output logic              DM_rDone,
   output logic              mem_req,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              err
);

   localparam int unsigned         STARVE_W  = $clog2(IM_STARVE_MAX + 1);
   localparam int unsigned         TCNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(IM_STARVE_MAX);
   localparam logic [TCNT_W-1:0]   TCNT_LAST = TCNT_W'(TIMEOUT - 1);

   arb_state_t          state_q, state_d;
   txn_t                txn_q;
   logic [STARVE_W-1:0] starve_q;
   logic [TCNT_W-1:0]   tcnt_q;
   logic                mem_req_q, err_q, abandon_q, deliver_q;
   logic [DATA_W-1:0]   im_do_q, dm_do_q;

   logic im_req, dm_req, grant_im, grant_dm;
   logic launch, busy, req_of_txn, timeout_hit, finish, keep;

   assign im_req      = IM_OE;
   assign dm_req      = DM_OE || (DM_WEB != WEB_NONE);
   assign launch      = (state_q == IDLE) && (grant_im || grant_dm);
   assign busy        = (state_q == IM_BUSY) || (state_q == DM_BUSY);
   assign req_of_txn  = txn_q.is_dm ? dm_req : im_req;
   assign timeout_hit = !mem_ack && (tcnt_q == TCNT_LAST);
   assign finish      = busy && (mem_ack || timeout_hit);
   // Result is only handed back to a read requester that held its request throughout.
   assign keep        = !abandon_q && req_of_txn && (txn_q.we == WEB_NONE);

   arb_priority #(
      .STARVE_MAX(IM_STARVE_MAX),
      .STARVE_W  (STARVE_W)
   ) u_prio (
      .im_req  (im_req),
      .dm_req  (dm_req),
      .starve  (starve_q),
      .grant_im(grant_im),
      .grant_dm(grant_dm)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_comb begin
      state_d  = state_q;
      IM_Stall = im_req && (state_q != IM_DONE);
      DM_Stall = dm_req && (state_q != DM_DONE);
      IM_rDone = (state_q == IM_DONE) && deliver_q;
      DM_rDone = (state_q == DM_DONE) && deliver_q;
      case (state_q)
         IDLE: begin
            if (grant_dm)      state_d = DM_BUSY;
            else if (grant_im) state_d = IM_BUSY;
         end
         IM_BUSY: if (finish) state_d = IM_DONE;
         DM_BUSY: if (finish) state_d = DM_DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         txn_q     <= '{addr: '0, wdata: '0, we: WEB_NONE, is_dm: 1'b0};
         starve_q  <= '0;
         tcnt_q    <= '0;
         mem_req_q <= 1'b0;
         err_q     <= 1'b0;
         abandon_q <= 1'b0;
         deliver_q <= 1'b0;
         im_do_q   <= '0;
         dm_do_q   <= '0;
      end else if (launch) begin
         txn_q.addr  <= grant_dm ? DM_A : IM_A;
         txn_q.wdata <= DM_DI;
         txn_q.we    <= grant_dm ? DM_WEB : WEB_NONE;
         txn_q.is_dm <= grant_dm;
         mem_req_q   <= 1'b1;
         tcnt_q      <= '0;
         abandon_q   <= 1'b0;
         if (grant_im)
            starve_q <= '0;
         else if (im_req && (starve_q != STARVE_LIM))
            starve_q <= starve_q + 1'b1;
      end else if (finish) begin
         mem_req_q <= 1'b0;
         deliver_q <= keep;
         if (timeout_hit) err_q <= 1'b1;
         if (keep) begin
            if (txn_q.is_dm) dm_do_q <= mem_ack ? mem_rdata : '0;
            else             im_do_q <= mem_ack ? mem_rdata : '0;
         end
      end else if (busy) begin
         tcnt_q <= tcnt_q + 1'b1;
         if (!req_of_txn) abandon_q <= 1'b1;
      end
   end

   assign mem_req   = mem_req_q;
   assign mem_we    = txn_q.we;
   assign mem_addr  = txn_q.addr;
   assign mem_wdata = txn_q.wdata;
   assign IM_DO     = im_do_q;
   assign DM_DO     = dm_do_q;
   assign err       = err_q;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed and randomized bench for cpu_mem_arbiter against a transaction-level reference model.
module tb_cpu_mem_arbiter;

   localparam int TO   = 255;
   localparam int SMAX = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        IM_OE = 1'b0, DM_OE = 1'b0, mem_ack = 1'b0;
   logic [3:0]  DM_WEB = 4'hF;
   logic [31:0] IM_A = '0, DM_A = '0, DM_DI = '0, mem_rdata = '0;
   logic [31:0] IM_DO, DM_DO, mem_addr, mem_wdata;
   logic [3:0]  mem_we;
   logic        IM_Stall, IM_rDone, DM_Stall, DM_rDone, mem_req, err;

   always #5 clk = ~clk;

   cpu_mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .TIMEOUT(TO), .IM_STARVE_MAX(SMAX)
   ) dut (
      .clk(clk), .rst(rst),
      .IM_OE(IM_OE), .IM_A(IM_A), .IM_DO(IM_DO), .IM_Stall(IM_Stall), .IM_rDone(IM_rDone),
      .DM_OE(DM_OE), .DM_WEB(DM_WEB), .DM_A(DM_A), .DM_DI(DM_DI), .DM_DO(DM_DO),
      .DM_Stall(DM_Stall), .DM_rDone(DM_rDone),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
   );

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  web;
      logic        oe;
   } dreq_t;

   int n_chk = 0, n_fail = 0;

   // CPU-side request sources and memory responder settings
   logic [31:0] im_q[$];
   dreq_t       dm_q[$];
   logic [31:0] data_q[$];
   bit          im_on = 0, dm_on = 0, dm_oe_cur = 0, drop_im = 0, stray = 0;
   logic [3:0]  dm_web_cur = 4'hF;
   int          ack_dly = 0;    // -1: never ack, -2: random 0..3

   // Reference model: phase 0 idle, 1 waiting on memory, 2 completion cycle
   int          ph = 0, who = 0, starve = 0, busy_n = 0, cur_dly = 0;
   bit          deliver = 0, is_rd = 0, err_m = 0;
   logic [31:0] exp_addr = '0, exp_wdata = '0, im_do_m = '0, dm_do_m = '0;
   logic [3:0]  exp_we = 4'hF;
   int          grants[$];
   int          im_done_cnt = 0, dm_done_cnt = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      bit          dmr, fin, dropped;
      logic [31:0] rd_val;
      dreq_t       d;
      @(negedge clk);
      dmr = DM_OE || (DM_WEB != 4'hF);
      rd_val = '0;
      if (ph == 1) begin
         deliver = deliver && ((who == 1) ? IM_OE : dmr);
         fin = 0;
         if (mem_ack) begin
            fin = 1; rd_val = mem_rdata;
         end else if (busy_n == TO) begin
            fin = 1; err_m = 1;
         end
         if (fin) begin
            ph = 2;
            if (deliver && is_rd) begin
               if (who == 1) im_do_m = rd_val; else dm_do_m = rd_val;
            end
         end else busy_n++;
      end else if (ph == 2) begin
         ph = 0;
      end else if (IM_OE || dmr) begin
         ph = 1; busy_n = 1; deliver = 1;
         if (dmr && (!IM_OE || starve < SMAX)) begin
            who = 2; exp_addr = DM_A; exp_we = DM_WEB; exp_wdata = DM_DI;
            is_rd = (DM_WEB == 4'hF);
            if (IM_OE) starve++;
         end else begin
            who = 1; exp_addr = IM_A; exp_we = 4'hF; is_rd = 1; starve = 0;
         end
         cur_dly = (ack_dly == -2) ? int'($urandom_range(0, 3)) : ack_dly;
      end

      chk("mem_req", mem_req, ph == 1);
      if (ph == 1) begin
         chk("mem_addr", mem_addr, exp_addr);
         chk("mem_we", mem_we, exp_we);
         if (!is_rd) chk("mem_wdata", mem_wdata, exp_wdata);
         if (busy_n == 1) grants.push_back((mem_addr >= 32'h8000) ? 2 : 1);
      end
      chk("IM_rDone", IM_rDone, ph == 2 && who == 1 && deliver);
      chk("DM_rDone", DM_rDone, ph == 2 && who == 2 && deliver && is_rd);
      chk("IM_Stall", IM_Stall, IM_OE && !(ph == 2 && who == 1));
      chk("DM_Stall", DM_Stall, dmr && !(ph == 2 && who == 2));
      chk("IM_DO", IM_DO, im_do_m);
      chk("DM_DO", DM_DO, dm_do_m);
      chk("err", err, err_m);
      if (IM_rDone === 1'b1) im_done_cnt++;
      if (DM_rDone === 1'b1) dm_done_cnt++;

      if (ph == 1 && cur_dly >= 0 && busy_n - 1 == cur_dly) begin
         mem_ack = 1'b1;
         mem_rdata = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
      end else begin
         mem_ack = stray; stray = 0; mem_rdata = $urandom;
      end

      // A requester advances when its completion cycle shows Stall low
      if (ph == 2 && deliver && who == 1) im_on = 0;
      if (ph == 2 && deliver && who == 2) dm_on = 0;
      dropped = 0;
      if (ph == 1 && who == 1 && busy_n == 1 && drop_im) begin
         im_on = 0; drop_im = 0; dropped = 1;
      end
      if (!im_on && !dropped && im_q.size() > 0) begin
         im_on = 1; IM_A = im_q.pop_front();
      end
      IM_OE = im_on;
      if (!dm_on && dm_q.size() > 0) begin
         d = dm_q.pop_front();
         dm_on = 1; DM_A = d.addr; DM_DI = d.wdata; dm_web_cur = d.web; dm_oe_cur = d.oe;
      end
      DM_OE  = dm_on && dm_oe_cur;
      DM_WEB = dm_on ? dm_web_cur : 4'hF;
   endtask

   task automatic drain(input int max);
      int n = 0;
      while ((im_q.size() > 0 || dm_q.size() > 0 || im_on || dm_on || ph != 0) && n < max) begin
         step();
         n++;
      end
      chk("drain_bound", n < max, 1);
   endtask

   task automatic check_reset_outputs();
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 32'hF);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_IM_rDone", IM_rDone, 0);
      chk("rst_DM_rDone", DM_rDone, 0);
      chk("rst_IM_DO", IM_DO, 0);
      chk("rst_DM_DO", DM_DO, 0);
      chk("rst_err", err, 0);
      chk("rst_stall", {IM_Stall, DM_Stall}, 0);
   endtask

   task automatic apply_reset();
      IM_OE = 0; DM_OE = 0; DM_WEB = 4'hF; mem_ack = 0;
      im_q.delete(); dm_q.delete(); data_q.delete();
      im_on = 0; dm_on = 0; drop_im = 0;
      rst = 1'b0;
      #1;
      check_reset_outputs();
      ph = 0; starve = 0; err_m = 0; im_do_m = '0; dm_do_m = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   dreq_t dr;

   initial begin
      #1 rst = 1'b0;
      #1 check_reset_outputs();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) step();

      // IM fetch, ack in the second busy cycle
      im_q.push_back(32'h100); data_q.push_back(32'h13); ack_dly = 1;
      drain(50);
      chk("im_only_do", IM_DO, 32'h13);
      chk("im_only_pulses", im_done_cnt, 1);

      // Simultaneous IM and DM read: DM goes first
      grants.delete(); ack_dly = 0;
      im_q.push_back(32'h104);
      dm_q.push_back('{addr: 32'h8000, wdata: '0, web: 4'hF, oe: 1'b1});
      data_q.push_back(32'h11111111); data_q.push_back(32'h22222222);
      drain(50);
      chk("simul_first", grants[0], 2);
      chk("simul_second", grants[1], 1);
      chk("simul_dm_do", DM_DO, 32'h11111111);
      chk("simul_im_do", IM_DO, 32'h22222222);

      // Byte write: no read pulse, DM_DO untouched
      dm_q.push_back('{addr: 32'h8004, wdata: 32'hAABBCCDD, web: 4'b1100, oe: 1'b0});
      drain(50);
      chk("write_no_pulse", dm_done_cnt, 1);
      chk("write_dm_do", DM_DO, 32'h11111111);

      // Starvation: IM held while DM streams reads
      grants.delete();
      im_q.push_back(32'h200);
      for (int i = 0; i < 6; i++)
         dm_q.push_back('{addr: 32'h8100 + 32'(4 * i), wdata: '0, web: 4'hF, oe: 1'b1});
      drain(100);
      for (int i = 0; i < 4; i++) chk("starve_dm", grants[i], 2);
      chk("starve_im", grants[4], 1);

      // Randomized mix of fetches, reads and writes with random ack latency
      ack_dly = -2;
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) != 0) im_q.push_back($urandom_range(0, 32'h7FFC) & ~32'h3);
         if ($urandom_range(0, 3) != 0) begin
            dr.addr  = 32'h8000 + ($urandom_range(0, 32'h7FFC) & ~32'h3);
            dr.wdata = $urandom;
            if ($urandom_range(0, 1) == 0) begin
               dr.web = 4'hF; dr.oe = 1'b1;
            end else begin
               dr.web = 4'($urandom_range(0, 14)); dr.oe = 1'($urandom_range(0, 1));
            end
            dm_q.push_back(dr);
         end
      end
      drain(3000);

      // IM drops its request mid-transaction: no pulse, IM_DO unchanged
      begin
         int         cnt0;
         logic [31:0] do0;
         cnt0 = im_done_cnt; do0 = im_do_m;
         ack_dly = 2; drop_im = 1; im_q.push_back(32'h300);
         drain(50);
         chk("drop_no_pulse", im_done_cnt, cnt0);
         chk("drop_do_kept", IM_DO, do0);
      end

      // Ack never arrives: timeout sets sticky err and returns zero
      begin
         int cnt0;
         cnt0 = im_done_cnt; ack_dly = -1;
         im_q.push_back(32'h400);
         drain(TO + 20);
         chk("timeout_err", err, 1);
         chk("timeout_do", IM_DO, 0);
         chk("timeout_pulse", im_done_cnt, cnt0 + 1);
         ack_dly = 0; im_q.push_back(32'h404); data_q.push_back(32'h5A5A5A5A);
         drain(50);
         chk("err_sticky", err, 1);
         chk("after_timeout_do", IM_DO, 32'h5A5A5A5A);
      end

      // Reset mid-busy, then a stray ack that must be ignored
      begin
         int guard = 0;
         int cnt0;
         ack_dly = -1;
         dm_q.push_back('{addr: 32'h8200, wdata: '0, web: 4'hF, oe: 1'b1});
         while (!(ph == 1 && busy_n >= 3) && guard < 20) begin
            step();
            guard++;
         end
         chk("busy_reached", ph, 1);
         apply_reset();
         cnt0 = dm_done_cnt + im_done_cnt;
         stray = 1;
         repeat (5) step();
         chk("stray_no_pulse", dm_done_cnt + im_done_cnt, cnt0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
